// File: rtl/seq_div_block.sv
// seq_div_block: multi-cycle 8-bit unsigned divide/modulo port on the OISC
// transport bus. A move into ADDR starts a restoring division of the
// accumulator by the moved value; quotient, remainder and status are read
// back through ADDR, ADDRI and ADDRS.
// Optional feature macro: SEQ_DIV_STALL_EN (stall the PC while a result read
// is pending on a busy divider). Default build ties stall to 0.
module seq_div_block #(
  parameter int                ADDR_W = 8,
  parameter logic [ADDR_W-1:0] ADDR   = 8'h00,
  parameter logic [ADDR_W-1:0] ADDRI  = 8'h01,
  parameter logic [ADDR_W-1:0] ADDRS  = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        acc,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_dst,
  input  logic [ADDR_W-1:0] bus_src,
  input  logic [7:0]        bus_wdata,
  output logic [7:0]        bus_rdata,
  output logic              bus_roe,
  output logic              busy,
  output logic              stall
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        busy_r;
  logic [2:0]  count_r;
  logic [7:0]  divisor_r;
  logic [7:0]  dividend_r;
  logic [7:0]  rem_work_r;
  logic [6:0]  quo_work_r;
  logic [7:0]  quotient_r;
  logic [7:0]  remainder_r;

  logic        start_s;
  logic        last_s;
  logic [8:0]  step_s;
  logic [7:0]  rem_next_s;
  logic        qbit_s;
  logic [7:0]  rdata_s;
  logic        roe_s;

  // One restoring-division step: shift in the next dividend bit and subtract
  // the divisor when it fits. When the subtraction happens the true
  // difference is below 256, so the low 8 bits are exact.
  // Returns {next partial remainder, quotient bit}.
  function automatic logic [8:0] div_step(input logic [7:0] rem,
                                          input logic       din,
                                          input logic [7:0] dsr);
    logic [8:0] trial;
    logic [7:0] diff;
    trial = {rem, din};
    diff  = trial[7:0] - dsr;
    if (trial >= {1'b0, dsr}) begin
      div_step = {diff, 1'b1};
    end else begin
      div_step = {trial[7:0], 1'b0};
    end
  endfunction

  assign start_s    = bus_we && (bus_dst == ADDR);
  assign last_s     = (state_r == ST_RUN) && (count_r == 3'd7);
  assign step_s     = div_step(rem_work_r, dividend_r[7], divisor_r);
  assign rem_next_s = step_s[8:1];
  assign qbit_s     = step_s[0];

  // Next-state logic: a start always (re)enters RUN, the 8th step returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start_s) begin
          state_s = ST_RUN;
        end else if (count_r == 3'd7) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
    end
  end

  // Datapath: operand capture on start, one dividend bit per RUN edge, and
  // publication of the result only on the final step so that partial values
  // never reach the readable registers. A start on the final edge still
  // publishes the completing result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= 3'd0;
      divisor_r   <= 8'h00;
      dividend_r  <= 8'h00;
      rem_work_r  <= 8'h00;
      quo_work_r  <= 7'h00;
      quotient_r  <= 8'h00;
      remainder_r <= 8'h00;
    end else begin
      if (start_s) begin
        divisor_r  <= bus_wdata;
        dividend_r <= acc;
        rem_work_r <= 8'h00;
        quo_work_r <= 7'h00;
        count_r    <= 3'd0;
      end else if (state_r == ST_RUN) begin
        dividend_r <= {dividend_r[6:0], 1'b0};
        rem_work_r <= rem_next_s;
        quo_work_r <= {quo_work_r[5:0], qbit_s};
        count_r    <= count_r + 3'd1;
      end else begin
        count_r    <= count_r;
      end
      if (last_s) begin
        quotient_r  <= {quo_work_r, qbit_s};
        remainder_r <= rem_next_s;
      end else begin
        quotient_r  <= quotient_r;
        remainder_r <= remainder_r;
      end
    end
  end

  // Zero-latency read mux from registered results and status.
  always_comb begin
    rdata_s = 8'h00;
    roe_s   = 1'b0;
    if (bus_src == ADDR) begin
      rdata_s = quotient_r;
      roe_s   = 1'b1;
    end else if (bus_src == ADDRI) begin
      rdata_s = remainder_r;
      roe_s   = 1'b1;
    end else if (bus_src == ADDRS) begin
      rdata_s = {7'd0, busy_r};
      roe_s   = 1'b1;
    end else begin
      rdata_s = 8'h00;
      roe_s   = 1'b0;
    end
  end

  assign bus_rdata = rdata_s;
  assign bus_roe   = roe_s;
  assign busy      = busy_r;

`ifdef SEQ_DIV_STALL_EN
  // Hold the PC while a quotient/remainder read targets an unfinished result;
  // status reads never stall.
  assign stall = busy_r & ((bus_src == ADDR) | (bus_src == ADDRI));
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_block.sv
// Scoreboard bench for seq_div_block: stimulus pushes expected
// {rdata, roe, busy, stall} per bus cycle; a monitor pops and compares.
module tb_seq_div_block;

`ifdef SEQ_DIV_STALL_EN
  localparam logic ST = 1'b1;
`else
  localparam logic ST = 1'b0;
`endif

  localparam logic [7:0] A_Q = 8'h00;
  localparam logic [7:0] A_R = 8'h01;
  localparam logic [7:0] A_S = 8'h02;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] acc = 8'h00;
  logic       bus_we = 1'b0;
  logic [7:0] bus_dst = 8'hF0;
  logic [7:0] bus_src = 8'hF0;
  logic [7:0] bus_wdata = 8'h00;
  logic [7:0] bus_rdata;
  logic       bus_roe;
  logic       busy;
  logic       stall;
  logic       probe = 1'b0;

  logic [10:0] sb[$];
  string       nm_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  seq_div_block dut (
    .clk(clk), .rst(rst), .acc(acc), .bus_we(bus_we), .bus_dst(bus_dst),
    .bus_src(bus_src), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_roe(bus_roe), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest expectation each probed cycle.
  always @(negedge clk) begin
    logic [10:0] e;
    string       nm;
    if (probe) begin
      n_cmp = n_cmp + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_empty: got rdata=%h with no expectation queued", bus_rdata);
      end else begin
        e  = sb.pop_front();
        nm = nm_q.pop_front();
        if ({bus_rdata, bus_roe, busy, stall} !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got rdata=%h roe=%b busy=%b stall=%b, want rdata=%h roe=%b busy=%b stall=%b",
                   nm, bus_rdata, bus_roe, busy, stall, e[10:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic mv(input logic we, input logic [7:0] dst, input logic [7:0] src,
                    input logic [7:0] wd, input logic [7:0] a, input logic [7:0] erd,
                    input logic eroe, input logic ebusy, input logic estall, input string nm);
    @(posedge clk);
    #1;
    bus_we    = we;
    bus_dst   = dst;
    bus_src   = src;
    bus_wdata = wd;
    acc       = a;
    sb.push_back({erd, eroe, ebusy, estall});
    nm_q.push_back(nm);
    probe = 1'b1;
  endtask

  task automatic rd(input logic [7:0] src, input logic [7:0] erd, input logic ebusy,
                    input logic estall, input string nm);
    mv(1'b0, 8'hF0, src, 8'h00, 8'h00, erd, 1'b1, ebusy, estall, nm);
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] d, input logic [7:0] src,
                       input logic [7:0] erd, input logic ebusy, input logic estall,
                       input string nm);
    mv(1'b1, A_Q, src, d, a, erd, 1'b1, ebusy, estall, nm);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Reset state
    rd(A_Q, 8'h00, 1'b0, 1'b0, "rst_quo");
    rd(A_R, 8'h00, 1'b0, 1'b0, "rst_rem");
    rd(A_S, 8'h00, 1'b0, 1'b0, "rst_status");

    // 100 / 7 = 14 r 2, busy through 8 cycles after the start edge
    start(8'd100, 8'd7, A_S, 8'h00, 1'b0, 1'b0, "t1_start");
    for (int i = 0; i < 8; i++) rd(A_S, 8'h01, 1'b1, 1'b0, "t1_busy_status");
    rd(A_Q, 8'd14, 1'b0, 1'b0, "t1_quo");
    rd(A_R, 8'd2, 1'b0, 1'b0, "t1_rem");
    rd(A_S, 8'h00, 1'b0, 1'b0, "t1_idle_status");

    // 0x2A / 0: quotient FF, remainder = dividend; start-cycle read sees old value
    start(8'h2A, 8'h00, A_Q, 8'd14, 1'b0, 1'b0, "t2_start_read_pre");
    for (int i = 0; i < 8; i++) rd(A_R, 8'd2, 1'b1, ST, "t2_hold_rem");
    rd(A_Q, 8'hFF, 1'b0, 1'b0, "t2_quo");
    rd(A_R, 8'h2A, 1'b0, 1'b0, "t2_rem");

    // 200/3 restarted at E+4 with 50/10: 66 never visible, then 5 r 0
    start(8'd200, 8'd3, A_R, 8'h2A, 1'b0, 1'b0, "t3_start");
    for (int i = 0; i < 3; i++) rd(A_Q, 8'hFF, 1'b1, ST, "t3_run_hold");
    start(8'd50, 8'd10, A_Q, 8'hFF, 1'b1, ST, "t3_restart");
    for (int i = 0; i < 8; i++) rd(A_Q, 8'hFF, 1'b1, ST, "t3_no_aborted");
    rd(A_Q, 8'd5, 1'b0, 1'b0, "t3_quo");
    rd(A_R, 8'd0, 1'b0, 1'b0, "t3_rem");

    // Reset mid 255/1, then 9/4 = 2 r 1
    start(8'd255, 8'd1, A_Q, 8'd5, 1'b0, 1'b0, "t4_start");
    rd(A_S, 8'h01, 1'b1, 1'b0, "t4_run");
    rd(A_S, 8'h01, 1'b1, 1'b0, "t4_run");
    rd(A_Q, 8'h00, 1'b0, 1'b0, "t4_rst_quo");
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    rd(A_R, 8'h00, 1'b0, 1'b0, "t4_rst_rem");
    start(8'd9, 8'd4, A_S, 8'h00, 1'b0, 1'b0, "t4b_start");
    for (int i = 0; i < 8; i++) rd(A_S, 8'h01, 1'b1, 1'b0, "t4b_busy");
    rd(A_Q, 8'd2, 1'b0, 1'b0, "t4b_quo");
    rd(A_R, 8'd1, 1'b0, 1'b0, "t4b_rem");

    // Writes to ADDRI / ADDRS are ignored
    mv(1'b1, A_R, A_S, 8'h33, 8'h77, 8'h00, 1'b1, 1'b0, 1'b0, "wr_addri_ignored");
    mv(1'b1, A_S, A_Q, 8'h44, 8'h77, 8'd2, 1'b1, 1'b0, 1'b0, "wr_addrs_ignored");
    rd(A_S, 8'h00, 1'b0, 1'b0, "wr_no_busy");
    rd(A_Q, 8'd2, 1'b0, 1'b0, "wr_quo_kept");
    rd(A_R, 8'd1, 1'b0, 1'b0, "wr_rem_kept");

    // 20/6 = 3 r 2; new start 81/9 on the completion edge publishes 3
    start(8'd20, 8'd6, A_S, 8'h00, 1'b0, 1'b0, "t5_start");
    for (int i = 0; i < 7; i++) rd(A_S, 8'h01, 1'b1, 1'b0, "t5_busy");
    start(8'd81, 8'd9, A_Q, 8'd2, 1'b1, ST, "t5_coincide");
    for (int i = 0; i < 8; i++) rd(A_Q, 8'd3, 1'b1, ST, "t5_prev_result");
    rd(A_Q, 8'd9, 1'b0, 1'b0, "t5_quo");
    rd(A_R, 8'd0, 1'b0, 1'b0, "t5_rem");

    // Unmatched source addresses
    mv(1'b0, 8'hF0, 8'h37, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "unmatched_37");
    mv(1'b0, 8'hF0, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "unmatched_03");

    @(posedge clk);
    #1 probe = 1'b0;
    n_cmp = n_cmp + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
